// File: rtl/elastic_pkg.sv
// Shared types and defaults for the elastic stream reduction stage.
package elastic_pkg;

  localparam int DATA_W = 32;
  localparam int ACC_W  = 40;
  localparam int BEATS  = 4;

  typedef logic [DATA_W-1:0] data_t;
  typedef logic [15:0]       beat_cnt_t;

  // Index of the beat that closes a frame.
  function automatic beat_cnt_t last_beat(input int beats);
    return beat_cnt_t'(beats - 1);
  endfunction

endpackage

// File: rtl/elastic_accum_if.sv
// Input word stream (t0_*) and frame-sum stream (i0_*) of the reduction stage.
interface elastic_accum_if #(
  parameter int DATA_W = elastic_pkg::DATA_W,
  parameter int ACC_W  = elastic_pkg::ACC_W
);

  logic [DATA_W-1:0] t0_data;
  logic              t0_valid;
  logic              t0_ready;
  logic [ACC_W-1:0]  i0_data;
  logic              i0_valid;
  logic              i0_ready;
  logic              i0_ovf;

  modport master (
    output t0_data, t0_valid, i0_ready,
    input  t0_ready, i0_data, i0_valid, i0_ovf
  );

  modport slave (
    input  t0_data, t0_valid, i0_ready,
    output t0_ready, i0_data, i0_valid, i0_ovf
  );

endinterface

// File: rtl/elastic_accum.sv
// Sums every BEATS accepted words into one ACC_W-bit result and re-emits it on
// an elastic output, one accepted word per cycle with no bubbles.
module elastic_accum #(
  parameter int DATA_W = elastic_pkg::DATA_W,
  parameter int ACC_W  = elastic_pkg::ACC_W,
  parameter int BEATS  = elastic_pkg::BEATS
) (
  input  logic                   clk,
  input  logic                   rst,
  elastic_accum_if.slave         bus,
  output elastic_pkg::beat_cnt_t frame_cnt
);

  import elastic_pkg::beat_cnt_t;
  import elastic_pkg::last_beat;

  if (ACC_W < DATA_W) begin : g_bad_acc_w
    $error("elastic_accum: ACC_W must be >= DATA_W");
  end
  if (BEATS < 1 || BEATS > 65535) begin : g_bad_beats
    $error("elastic_accum: BEATS must be in 1..65535");
  end

  localparam int        SUM_W = ACC_W + 1;
  localparam beat_cnt_t LAST  = last_beat(BEATS);

  logic [ACC_W-1:0] acc;
  logic             ovf_acc;
  beat_cnt_t        beat_cnt;
  logic [ACC_W-1:0] res_data;
  logic             res_valid;
  logic             res_ovf;

  logic             final_beat;
  logic             acc_t;
  logic             acc_i;
  logic [SUM_W-1:0] sum;

  // One extra bit keeps the carry-out of the running add.
  assign sum        = SUM_W'(acc) + SUM_W'(bus.t0_data);
  assign final_beat = (beat_cnt == LAST);

  // Only the frame-closing beat can stall, and only while an untaken result
  // still occupies the output register.
  assign bus.t0_ready = ~rst & ~(final_beat & res_valid & ~bus.i0_ready);
  assign acc_t        = bus.t0_valid & bus.t0_ready;
  assign acc_i        = res_valid & bus.i0_ready;

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register here samples the pre-edge values of all the others.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc       <= '0;
      ovf_acc   <= 1'b0;
      beat_cnt  <= '0;
      res_data  <= '0;
      res_valid <= 1'b0;
      res_ovf   <= 1'b0;
      frame_cnt <= '0;
    end else begin
      if (acc_i) begin
        frame_cnt <= frame_cnt + 16'd1;
      end

      if (acc_t && final_beat) begin
        // A new result may overwrite one taken in this same cycle.
        res_data  <= sum[ACC_W-1:0];
        res_ovf   <= ovf_acc | sum[ACC_W];
        res_valid <= 1'b1;
        acc       <= '0;
        ovf_acc   <= 1'b0;
        beat_cnt  <= '0;
      end else begin
        if (acc_i) begin
          res_valid <= 1'b0;
        end
        if (acc_t) begin
          acc      <= sum[ACC_W-1:0];
          ovf_acc  <= ovf_acc | sum[ACC_W];
          beat_cnt <= beat_cnt + 16'd1;
        end
      end
    end
  end

  assign bus.i0_data  = res_data;
  assign bus.i0_valid = res_valid;
  assign bus.i0_ovf   = res_ovf;

endmodule
